// File: rtl/mux_2x1_if.sv
// Bundle of the data, select and status signals around the 2:1 selector.
// The master side drives data, select and enable; the slave side is the selector itself.
interface mux_2x1_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             sel;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic [CNT_W-1:0] sel_switch_cnt;

    modport master (
        output inp1,
        output inp2,
        output sel,
        output en,
        input  out,
        input  out_q,
        input  sel_q,
        input  sel_switch_cnt
    );

    modport slave (
        input  inp1,
        input  inp2,
        input  sel,
        input  en,
        output out,
        output out_q,
        output sel_q,
        output sel_switch_cnt
    );
endinterface

// File: rtl/mux_2x1.sv
// Parameterised 2:1 data selector with a zero-latency output, a registered
// copy of the result, the registered select and a saturating count of select changes.
module mux_2x1 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    mux_2x1_if.slave    bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mux_val;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             sel_d;
    logic             sel_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Combinational selection; reset and enable never touch this path.
    always_comb begin
        mux_val = bus.sel ? bus.inp2 : bus.inp1;
    end

    // Next-state for the registered copies; a disabled cycle holds everything.
    always_comb begin
        out_d = out_q;
        sel_d = sel_q;
        cnt_d = cnt_q;
        if (bus.en) begin
            out_d = mux_val;
            sel_d = bus.sel;
            if ((bus.sel != sel_q) && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Registered state, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.out            = mux_val;
    assign bus.out_q          = out_q;
    assign bus.sel_q          = sel_q;
    assign bus.sel_switch_cnt = cnt_q;
endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: table-driven vectors with a scoreboard
// for the registered outputs, plus hand-written reset and saturation sequences.
module tb_mux_2x1;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int NUM_VECS = 11;
    localparam int SAT_EDGES = (1 << CNT_W) + 5;

    typedef struct {
        logic [WIDTH-1:0] inp1;
        logic [WIDTH-1:0] inp2;
        logic             sel;
        logic             en;
        logic [WIDTH-1:0] exp_out;
        logic [WIDTH-1:0] exp_out_q;
        logic             exp_sel_q;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] out_q;
        logic             sel_q;
        logic [CNT_W-1:0] cnt;
    } exp_reg_t;

    logic     clk;
    logic     rst;
    int       tests_run;
    int       tests_failed;
    vec_t     vecs [NUM_VECS];
    exp_reg_t scoreboard [$];

    mux_2x1_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux_2x1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pop the oldest expected registered state and compare it with the DUT.
    task automatic checkRegistered(input string name);
        exp_reg_t e;
        if (scoreboard.size() == 0) begin
            checkOutput({name, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({name, "_out_q"}, bus.out_q, e.out_q);
            checkOutput({name, "_sel_q"}, 32'(bus.sel_q), 32'(e.sel_q));
            checkOutput({name, "_cnt"}, 32'(bus.sel_switch_cnt), 32'(e.cnt));
        end
    endtask

    // Drive one vector at the falling edge, check the combinational result,
    // queue the expected registered state and compare it after the rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_reg_t e;
        @(negedge clk);
        bus.inp1 = v.inp1;
        bus.inp2 = v.inp2;
        bus.sel  = v.sel;
        bus.en   = v.en;
        #1;
        checkOutput($sformatf("vec%0d_out", idx), bus.out, v.exp_out);
        e.out_q = v.exp_out_q;
        e.sel_q = v.exp_sel_q;
        e.cnt   = v.exp_cnt;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkRegistered($sformatf("vec%0d", idx));
    endtask

    initial begin
        int exp_cnt;
        tests_run    = 0;
        tests_failed = 0;

        //           inp1          inp2          sel   en    out           out_q         sel_q cnt
        vecs[0]  = '{32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 16'd0};
        vecs[1]  = '{32'd10,       32'd20,       1'b0, 1'b1, 32'd10,       32'd10,       1'b0, 16'd0};
        vecs[2]  = '{32'd10,       32'd20,       1'b1, 1'b1, 32'd20,       32'd20,       1'b1, 16'd1};
        vecs[3]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hAAAAAAAA, 32'd20,       1'b1, 16'd1};
        vecs[4]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h55555555, 32'd20,       1'b1, 16'd1};
        vecs[5]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hAAAAAAAA, 32'd20,       1'b1, 16'd1};
        vecs[6]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 16'd2};
        vecs[7]  = '{32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 16'd3};
        vecs[8]  = '{32'hDEADBEEF, 32'h00000001, 1'b1, 1'b1, 32'h00000001, 32'h00000001, 1'b1, 16'd3};
        vecs[9]  = '{32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 16'd4};
        vecs[10] = '{32'h0,        32'd20,       1'b1, 1'b1, 32'd20,       32'd20,       1'b1, 16'd5};

        // Reset with all inputs zero.
        rst      = 1'b1;
        bus.inp1 = '0;
        bus.inp2 = '0;
        bus.sel  = 1'b0;
        bus.en   = 1'b0;
        #10;
        checkOutput("reset_out", bus.out, 32'h0);
        checkOutput("reset_out_q", bus.out_q, 32'h0);
        checkOutput("reset_sel_q", 32'(bus.sel_q), 32'h0);
        checkOutput("reset_cnt", 32'(bus.sel_switch_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset between edges while out_q=20 and cnt=5.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_q", bus.out_q, 32'h0);
        checkOutput("async_rst_sel_q", 32'(bus.sel_q), 32'h0);
        checkOutput("async_rst_cnt", 32'(bus.sel_switch_cnt), 32'h0);
        checkOutput("async_rst_out", bus.out, 32'd20);
        bus.inp1 = 32'd77;
        bus.sel  = 1'b0;
        #1;
        checkOutput("rst_out_tracks", bus.out, 32'd77);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_out_q", bus.out_q, 32'h0);
        checkOutput("rst_hold_cnt", 32'(bus.sel_switch_cnt), 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        bus.sel  = 1'b1;
        bus.inp2 = 32'd20;
        bus.en   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_out_q", bus.out_q, 32'd20);
        checkOutput("post_rst_sel_q", 32'(bus.sel_q), 32'h1);
        checkOutput("post_rst_cnt", 32'(bus.sel_switch_cnt), 32'h1);

        // Saturation: toggle sel on every enabled edge from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        bus.en  = 1'b1;
        for (int i = 0; i < SAT_EDGES; i++) begin
            @(negedge clk);
            bus.sel = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            exp_cnt = (i + 1 < 65535) ? (i + 1) : 65535;
            if (i == 65533 || i == 65534 || i == SAT_EDGES - 1) begin
                checkOutput($sformatf("sat_cnt_edge%0d", i + 1), 32'(bus.sel_switch_cnt), 32'(exp_cnt));
            end
        end
        checkOutput("sat_final_cnt", 32'(bus.sel_switch_cnt), 32'hFFFF);
        checkOutput("sat_final_sel_q", 32'(bus.sel_q), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mux_2x1.md
Name: mux_2x1

Overview:
- Parameterised 2:1 data selector used throughout the pipelined RISC-V datapath, e.g. for PC source, ALU operand B and writeback selection.
- Primary output `out` is purely combinational: `sel=0` passes `inp1`, `sel=1` passes `inp2`.
- A registered copy of the output, plus select-activity status, is provided for pipeline-stage use and debug visibility.

Parameters:
- WIDTH, 32, data width of inp1, inp2, out and out_q.
- CNT_W, 16, width of the select-switch counter.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  asynchronous active-high reset.
- inp1  input  WIDTH  data input selected when sel=0.
- inp2  input  WIDTH  data input selected when sel=1.
- sel  input  1  select; 0 chooses inp1, 1 chooses inp2.
- en  input  1  register enable for out_q, sel_q and sel_switch_cnt.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result.
- sel_q  output  1  registered select.
- sel_switch_cnt  output  CNT_W  saturating count of select changes.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-high (rst).
- Combinational path:
  - out = sel ? inp2 : inp1, zero latency, independent of clk, rst and en.
  - out reflects input changes within the same delta/settle time.
  - Reset does not force out; out tracks the inputs even while rst=1.
  - All inputs 0 gives out=0.
- Reset (asynchronous):
  - rst=1 immediately forces out_q=0, sel_q=0, sel_switch_cnt=0, without waiting for a clock edge.
  - These values are held while rst=1.
  - Normal operation resumes at the first rising clk edge after rst deasserts.
  - Reset asserted mid-operation discards the registered state; the combinational out is unaffected.
- Registered path (rising clk, rst=0):
  - en=1: out_q <= (sel ? inp2 : inp1); sel_q <= sel.
  - en=1 and sel != sel_q: sel_switch_cnt increments by 1.
  - The counter saturates at all-ones (2^CNT_W-1) and never wraps.
  - en=0: out_q, sel_q and sel_switch_cnt all hold.
  - Latency from input to out_q is 1 clock.
- Arithmetic and widths:
  - No sign or width conversion; the bitwise selection is full-width.
  - A sel value of X/Z is not supported; the design treats sel as 2-state.
- Simultaneous events:
  - rst takes priority over en.
  - If sel changes on the same edge it is sampled, the new value is registered and the counter compares it against the previous sel_q.

Test Plan:
- inp1=0, inp2=0, sel=0, wait 10 -> out=0; after rst pulse, out_q=0, sel_q=0, cnt=0.
- inp1=10, inp2=20, sel=0, wait 10 -> out=10; after 1 enabled clk, out_q=10.
- inp1=10, inp2=20, sel=1, wait 10 -> out=20; after 1 enabled clk, out_q=20, sel_q=1, cnt=1.
- en=0, toggle sel 0/1/0 across 3 clks with inp1=0xAAAAAAAA, inp2=0x55555555 -> out follows sel each cycle; out_q, sel_q, cnt unchanged.
- Toggle sel every enabled clk for 2^CNT_W+5 cycles -> cnt stops at 0xFFFF and does not wrap.
- Assert rst between clock edges while out_q=20, cnt=5 -> out_q=0 and cnt=0 immediately; out still equals the selected input.
